// File: rtl/router_pkt_if.sv
// Byte-stream bundle between the router input port, the packet datapath and the FIFO write side.
interface router_pkt_if #(
   parameter int WIDTH     = 8,
   parameter int ADDR_BITS = 2
);
   logic                 pkt_valid;
   logic [WIDTH-1:0]     data_in;
   logic                 fifo_full;
   logic                 busy;
   logic [WIDTH-1:0]     dout;
   logic                 dout_valid;
   logic [ADDR_BITS-1:0] dest_addr;
   logic                 parity_done;
   logic                 err_parity;
   logic                 err_length;
   logic                 pkt_done;

   modport master (
      output pkt_valid, data_in, fifo_full,
      input  busy, dout, dout_valid, dest_addr, parity_done, err_parity, err_length, pkt_done
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full,
      output busy, dout, dout_valid, dest_addr, parity_done, err_parity, err_length, pkt_done
   );
endinterface

// File: rtl/router_pkt_datapath.sv
// Packet datapath: header split, XOR parity and length check, in-order forwarding through a skid buffer.
module router_pkt_datapath #(
   parameter int WIDTH      = 8,
   parameter int ADDR_BITS  = 2,
   parameter int SKID_DEPTH = 2
) (
   input logic         clock,
   input logic         reset,
   router_pkt_if.slave bus
);
   localparam int LEN_W = WIDTH - ADDR_BITS;
   localparam int CNT_W = LEN_W + 1;
   localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int SC_W  = $clog2(SKID_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {LEN_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] skid_mem [SKID_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [SC_W-1:0]  skid_cnt;
   logic [LEN_W-1:0] len;
   logic [CNT_W-1:0] pay_cnt;
   logic [WIDTH-1:0] parity_acc, pkt_parity;
   logic             busy, accept, skid_empty, do_pop, do_push, check_go;

   assign skid_empty = (skid_cnt == '0);
   assign busy       = (skid_cnt == SC_W'(SKID_DEPTH)) || (state == CHECK);
   assign accept     = !busy && ((state == IDLE && bus.pkt_valid) || state == PAYLOAD);
   assign do_pop     = !bus.fifo_full && !skid_empty;
   // A byte bypasses the skid only when the FIFO can take it and nothing older is queued.
   assign do_push    = accept && (bus.fifo_full || !skid_empty);
   assign check_go   = (state == CHECK) && skid_empty;
   assign bus.busy   = busy;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = PAYLOAD;
         PAYLOAD: if (accept && !bus.pkt_valid) state_next = CHECK;
         CHECK:   if (skid_empty) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (do_push) skid_mem[wr_ptr] <= bus.data_in;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         skid_cnt <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_W'(SKID_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(SKID_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   skid_cnt <= skid_cnt + 1'b1;
            2'b01:   skid_cnt <= skid_cnt - 1'b1;
            default: skid_cnt <= skid_cnt;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
      end else if (bus.fifo_full) begin
         bus.dout_valid <= 1'b0;
      end else if (!skid_empty) begin
         bus.dout       <= skid_mem[rd_ptr];
         bus.dout_valid <= 1'b1;
      end else if (accept) begin
         bus.dout       <= bus.data_in;
         bus.dout_valid <= 1'b1;
      end else begin
         bus.dout_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.dest_addr   <= '0;
         len             <= '0;
         pay_cnt         <= '0;
         parity_acc      <= '0;
         pkt_parity      <= '0;
         bus.parity_done <= 1'b0;
         bus.err_parity  <= 1'b0;
         bus.err_length  <= 1'b0;
         bus.pkt_done    <= 1'b0;
      end else begin
         bus.pkt_done <= 1'b0;
         if (accept && state == IDLE) begin
            bus.dest_addr   <= bus.data_in[ADDR_BITS-1:0];
            len             <= bus.data_in[WIDTH-1:ADDR_BITS];
            parity_acc      <= bus.data_in;
            pay_cnt         <= '0;
            bus.parity_done <= 1'b0;
            bus.err_parity  <= 1'b0;
            bus.err_length  <= 1'b0;
         end else if (accept && state == PAYLOAD) begin
            if (bus.pkt_valid) begin
               parity_acc <= parity_acc ^ bus.data_in;
               if (pay_cnt != CNT_MAX) pay_cnt <= pay_cnt + 1'b1;
            end else begin
               pkt_parity <= bus.data_in;
            end
         end
         if (check_go) begin
            bus.err_parity  <= (parity_acc != pkt_parity);
            bus.err_length  <= (pay_cnt != {1'b0, len});
            bus.parity_done <= 1'b1;
            bus.pkt_done    <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_router_pkt_datapath.sv
// Directed self-checking bench for router_pkt_datapath with the default parameters.
module tb_router_pkt_datapath;
   logic clock;
   logic reset;
   int   vectors    = 0;
   int   miscompares = 0;
   int   mark;
   logic [7:0] wr_log [$];

   router_pkt_if #(.WIDTH(8), .ADDR_BITS(2)) bus ();

   router_pkt_datapath #(.WIDTH(8), .ADDR_BITS(2), .SKID_DEPTH(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Every byte the FIFO actually takes, in write order.
   always @(posedge clock) begin
      if (bus.dout_valid) wr_log.push_back(bus.dout);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents a byte at the current negedge, holds it while busy, returns at the negedge after acceptance.
   task automatic applyStimulus(input logic pv, input logic [7:0] d);
      int guard = 0;
      bus.pkt_valid = pv;
      bus.data_in   = d;
      while (bus.busy && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 50) checkOutput("busy_timeout", 32'd1, 32'd0);
      @(negedge clock);
   endtask

   initial begin
      reset         = 1'b1;
      bus.pkt_valid = 1'b0;
      bus.data_in   = 8'h00;
      bus.fifo_full = 1'b0;
      @(negedge clock);
      checkOutput("rst_dout_valid", bus.dout_valid, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_parity_done", bus.parity_done, 0);
      checkOutput("rst_pkt_done", bus.pkt_done, 0);
      reset = 1'b0;
      @(negedge clock);

      // Good packet, FIFO always ready: one-cycle latency per byte.
      applyStimulus(1'b1, 8'h0D);
      checkOutput("t1_hdr_dout", {bus.dout_valid, bus.dout}, 9'h10D);
      checkOutput("t1_dest", bus.dest_addr, 1);
      applyStimulus(1'b1, 8'h11);
      checkOutput("t1_p0_dout", {bus.dout_valid, bus.dout}, 9'h111);
      applyStimulus(1'b1, 8'h22);
      checkOutput("t1_p1_dout", {bus.dout_valid, bus.dout}, 9'h122);
      applyStimulus(1'b1, 8'h33);
      checkOutput("t1_p2_dout", {bus.dout_valid, bus.dout}, 9'h133);
      applyStimulus(1'b0, 8'h0D);
      checkOutput("t1_par_dout", {bus.dout_valid, bus.dout}, 9'h10D);
      checkOutput("t1_check_busy", bus.busy, 1);
      checkOutput("t1_pre_done", bus.pkt_done, 0);
      @(negedge clock);
      checkOutput("t1_pkt_done", bus.pkt_done, 1);
      checkOutput("t1_flags", {bus.parity_done, bus.err_parity, bus.err_length}, 3'b100);
      checkOutput("t1_dv_idle", bus.dout_valid, 0);
      @(negedge clock);
      checkOutput("t1_pulse_end", bus.pkt_done, 0);

      // Bad parity byte.
      applyStimulus(1'b1, 8'h0D);
      checkOutput("t2_hdr_clear", bus.parity_done, 0);
      applyStimulus(1'b1, 8'h11);
      applyStimulus(1'b1, 8'h22);
      applyStimulus(1'b1, 8'h33);
      applyStimulus(1'b0, 8'h0C);
      @(negedge clock);
      checkOutput("t2_pkt_done", bus.pkt_done, 1);
      checkOutput("t2_flags", {bus.parity_done, bus.err_parity, bus.err_length}, 3'b110);
      @(negedge clock);
      checkOutput("t2_flags_hold", {bus.parity_done, bus.err_parity, bus.err_length}, 3'b110);

      // Short payload: length error only.
      applyStimulus(1'b1, 8'h0D);
      checkOutput("t3_hdr_clear", {bus.parity_done, bus.err_parity, bus.err_length}, 3'b000);
      applyStimulus(1'b1, 8'h11);
      applyStimulus(1'b1, 8'h22);
      applyStimulus(1'b0, 8'h3E);
      @(negedge clock);
      checkOutput("t3_flags", {bus.pkt_done, bus.parity_done, bus.err_parity, bus.err_length}, 4'b1101);
      @(negedge clock);

      // FIFO full from the header: skid fills, then drains in order.
      mark = wr_log.size();
      bus.fifo_full = 1'b1;
      applyStimulus(1'b1, 8'h0D);
      checkOutput("t4_hdr_dv", bus.dout_valid, 0);
      checkOutput("t4_hdr_busy", bus.busy, 0);
      applyStimulus(1'b1, 8'h11);
      checkOutput("t4_full_busy", bus.busy, 1);
      bus.data_in = 8'h22;
      @(negedge clock);
      checkOutput("t4_hold_busy", bus.busy, 1);
      checkOutput("t4_hold_dout", {bus.dout_valid, bus.dout}, 9'h03E);
      bus.fifo_full = 1'b0;
      @(negedge clock);
      checkOutput("t4_pop0", {bus.dout_valid, bus.dout}, 9'h10D);
      checkOutput("t4_busy_drop", bus.busy, 0);
      applyStimulus(1'b1, 8'h22);
      checkOutput("t4_pop1", {bus.dout_valid, bus.dout}, 9'h111);
      applyStimulus(1'b1, 8'h33);
      checkOutput("t4_pop2", {bus.dout_valid, bus.dout}, 9'h122);
      applyStimulus(1'b0, 8'h0D);
      checkOutput("t4_pop3", {bus.dout_valid, bus.dout}, 9'h133);
      @(negedge clock);
      checkOutput("t4_pop4", {bus.dout_valid, bus.dout}, 9'h10D);
      checkOutput("t4_not_done", bus.pkt_done, 0);
      @(negedge clock);
      checkOutput("t4_flags", {bus.pkt_done, bus.parity_done, bus.err_parity, bus.err_length}, 4'b1100);
      checkOutput("t4_count", wr_log.size() - mark, 5);
      if (wr_log.size() - mark == 5) begin
         checkOutput("t4_stream", {wr_log[mark], wr_log[mark+1], wr_log[mark+2], wr_log[mark+3], wr_log[mark+4]},
                     40'h0D1122330D);
      end

      // Zero-length packet.
      mark = wr_log.size();
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b0, 8'h00);
      @(negedge clock);
      checkOutput("t5_flags", {bus.pkt_done, bus.parity_done, bus.err_parity, bus.err_length}, 4'b1100);
      checkOutput("t5_dest", bus.dest_addr, 0);
      checkOutput("t5_count", wr_log.size() - mark, 2);

      // Asynchronous reset with one byte parked in the skid.
      bus.fifo_full = 1'b1;
      applyStimulus(1'b1, 8'h0F);
      checkOutput("t6_dest_pre", bus.dest_addr, 3);
      bus.data_in = 8'h11;
      #2 reset = 1'b1;
      #1;
      checkOutput("t6_rst_dest", bus.dest_addr, 0);
      checkOutput("t6_rst_out", {bus.busy, bus.dout_valid, bus.dout, bus.parity_done, bus.pkt_done}, 12'h000);
      @(negedge clock);
      reset         = 1'b0;
      bus.fifo_full = 1'b0;
      bus.pkt_valid = 1'b0;
      @(negedge clock);
      mark = wr_log.size();
      applyStimulus(1'b1, 8'h05);
      checkOutput("t6_hdr_dout", {bus.dout_valid, bus.dout}, 9'h105);
      checkOutput("t6_dest", bus.dest_addr, 1);
      applyStimulus(1'b1, 8'hAA);
      checkOutput("t6_pay_dout", {bus.dout_valid, bus.dout}, 9'h1AA);
      applyStimulus(1'b0, 8'hAF);
      checkOutput("t6_par_dout", {bus.dout_valid, bus.dout}, 9'h1AF);
      @(negedge clock);
      checkOutput("t6_flags", {bus.pkt_done, bus.parity_done, bus.err_parity, bus.err_length}, 4'b1100);
      checkOutput("t6_count", wr_log.size() - mark, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
